// File: rtl/sync_ram_dp.sv
// Dual-port word RAM (A read/write with byte lanes, B read-only) with hardware clear sweep.
// Reads: 1-cycle latency with valid/err strobes. No backpressure; busy drops all requests while clearing.
module sync_ram_dp #(
  parameter int ADR     = 10,
  parameter int DAT     = 32,
  parameter int DPTH    = 1024,
  parameter int RD_MODE = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             clr_req,
  output logic             busy,
  input  logic             a_en,
  input  logic             a_we,
  input  logic [DAT/8-1:0] a_be,
  input  logic [ADR-1:0]   a_addr,
  input  logic [DAT-1:0]   a_din,
  output logic [DAT-1:0]   a_dout,
  output logic             a_valid,
  output logic             a_err,
  input  logic             b_en,
  input  logic [ADR-1:0]   b_addr,
  output logic [DAT-1:0]   b_dout,
  output logic             b_valid,
  output logic             b_err
);

  localparam int LANES = DAT / 8;
  localparam int IDXW  = (DPTH > 1) ? $clog2(DPTH) : 1;
  localparam logic [ADR:0]    DPTH_W = (ADR + 1)'(DPTH);
  localparam logic [IDXW-1:0] LAST   = IDXW'(DPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic [DAT-1:0] mem [DPTH];

  logic            go;
  logic            a_in_rng, b_in_rng;
  logic            a_wr_ok, a_rd_ok, a_bad;
  logic            b_rd_ok, b_bad;
  logic [IDXW-1:0] a_idx, b_idx;
  logic [DAT-1:0]  a_merged, b_rd_word;

  // Range is checked on the full address so out-of-range words never alias onto low indices.
  assign a_in_rng = {1'b0, a_addr} < DPTH_W;
  assign b_in_rng = {1'b0, b_addr} < DPTH_W;
  assign a_idx    = a_addr[IDXW-1:0];
  assign b_idx    = b_addr[IDXW-1:0];

  // clr_req wins over any port request issued in the same cycle.
  assign go      = (state_q == ST_IDLE) && !clr_req;
  assign a_wr_ok = go && a_en && a_in_rng && a_we;
  assign a_rd_ok = go && a_en && a_in_rng && !a_we;
  assign a_bad   = go && a_en && !a_in_rng;
  assign b_rd_ok = go && b_en && b_in_rng;
  assign b_bad   = go && b_en && !b_in_rng;
  assign busy    = (state_q == ST_CLEAR);

  always_comb begin
    a_merged = mem[a_idx];
    for (int k = 0; k < LANES; k++) begin
      if (a_be[k]) a_merged[8*k +: 8] = a_din[8*k +: 8];
    end
  end

  assign b_rd_word = (RD_MODE == 1 && a_wr_ok && a_idx == b_idx) ? a_merged : mem[b_idx];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array has no reset; the clear sweep owns it while busy.
  always_ff @(posedge Clk) begin
    if (state_q == ST_CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (a_wr_ok) begin
      mem[a_idx] <= a_merged;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      a_dout  <= '0;
      b_dout  <= '0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      a_err   <= 1'b0;
      b_err   <= 1'b0;
    end else begin
      a_valid <= a_rd_ok;
      b_valid <= b_rd_ok;
      a_err   <= a_bad;
      b_err   <= b_bad;
      if (a_rd_ok) a_dout <= mem[a_idx];
      if (b_rd_ok) b_dout <= b_rd_word;
    end
  end

endmodule

// File: tb/tb_sync_ram_dp.sv
// Directed bench for sync_ram_dp: two instances (RD_MODE 0 and 1) share stimulus and a word-level model.
module tb_sync_ram_dp;

  localparam int DPTH = 16;

  logic        Clk, reset, clr_req;
  logic        a_en, a_we, b_en;
  logic [3:0]  a_be;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_din;

  logic        busy0, a_valid0, a_err0, b_valid0, b_err0;
  logic [31:0] a_dout0, b_dout0;
  logic        busy1, a_valid1, a_err1, b_valid1, b_err1;
  logic [31:0] a_dout1, b_dout1;

  int n_vec = 0;
  int n_bad = 0;

  sync_ram_dp #(.ADR(5), .DAT(32), .DPTH(DPTH), .RD_MODE(0)) u0 (
    .Clk(Clk), .reset(reset), .clr_req(clr_req), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout0), .a_valid(a_valid0), .a_err(a_err0),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout0), .b_valid(b_valid0), .b_err(b_err0)
  );

  sync_ram_dp #(.ADR(5), .DAT(32), .DPTH(DPTH), .RD_MODE(1)) u1 (
    .Clk(Clk), .reset(reset), .clr_req(clr_req), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout1), .a_valid(a_valid1), .a_err(a_err1),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout1), .b_valid(b_valid1), .b_err(b_err1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: word array plus a count of remaining busy cycles.
  logic [31:0] mdl [DPTH];
  int          clr_left;
  logic [31:0] ea_dout, eb0_dout, eb1_dout;
  logic        ea_valid, ea_err, eb_valid, eb_err;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = din[8*k +: 8];
    return r;
  endfunction

  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      clr_left = DPTH;
      for (int i = 0; i < DPTH; i++) mdl[i] = '0;
      ea_dout = '0; eb0_dout = '0; eb1_dout = '0;
      ea_valid = 0; ea_err = 0; eb_valid = 0; eb_err = 0;
    end else begin
      ea_valid = 0; ea_err = 0; eb_valid = 0; eb_err = 0;
      if (clr_left > 0) begin
        clr_left--;
      end else if (clr_req) begin
        clr_left = DPTH;
        for (int i = 0; i < DPTH; i++) mdl[i] = '0;
      end else begin
        if (b_en) begin
          if (int'(b_addr) < DPTH) begin
            eb_valid = 1;
            eb0_dout = mdl[int'(b_addr)];
            eb1_dout = (a_en && a_we && a_addr == b_addr)
                     ? merge(mdl[int'(b_addr)], a_din, a_be) : mdl[int'(b_addr)];
          end else eb_err = 1;
        end
        if (a_en) begin
          if (int'(a_addr) < DPTH) begin
            if (a_we) mdl[int'(a_addr)] = merge(mdl[int'(a_addr)], a_din, a_be);
            else begin
              ea_valid = 1;
              ea_dout  = mdl[int'(a_addr)];
            end
          end else ea_err = 1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    chk("busy0", {31'b0, busy0}, {31'b0, clr_left > 0});
    chk("busy1", {31'b0, busy1}, {31'b0, clr_left > 0});
    chk("a_valid0", {31'b0, a_valid0}, {31'b0, ea_valid});
    chk("a_err0", {31'b0, a_err0}, {31'b0, ea_err});
    chk("b_valid0", {31'b0, b_valid0}, {31'b0, eb_valid});
    chk("b_err0", {31'b0, b_err0}, {31'b0, eb_err});
    chk("a_valid1", {31'b0, a_valid1}, {31'b0, ea_valid});
    chk("b_err1", {31'b0, b_err1}, {31'b0, eb_err});
    chk("a_dout0", a_dout0, ea_dout);
    chk("a_dout1", a_dout1, ea_dout);
    chk("b_dout0", b_dout0, eb0_dout);
    chk("b_dout1", b_dout1, eb1_dout);
  end

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic idle();
    a_en = 0; a_we = 0; b_en = 0; clr_req = 0;
  endtask

  task automatic wr(input int adr, input logic [31:0] d, input logic [3:0] be);
    a_en = 1; a_we = 1; a_addr = 5'(adr); a_din = d; a_be = be;
  endtask

  task automatic rd_a(input int adr);
    a_en = 1; a_we = 0; a_addr = 5'(adr);
  endtask

  task automatic rd_b(input int adr);
    b_en = 1; b_addr = 5'(adr);
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (busy0 && n < 40) begin
      step();
      n++;
    end
    chk(nm, n, 16);
  endtask

  initial begin
    reset = 1; clr_req = 0; a_en = 0; a_we = 0; b_en = 0;
    a_be = '0; a_addr = '0; a_din = '0; b_addr = '0;
    step(); step();
    chk("rst_busy", {31'b0, busy0}, 1);
    chk("rst_a_dout", a_dout0, 0);
    reset = 0;
    count_busy("busy_after_reset");

    for (int i = 0; i < DPTH; i++) begin
      rd_b(i); step();
      chk("zero_b_dout", b_dout0, 32'h0);
      chk("zero_b_valid", {31'b0, b_valid0}, 1);
    end
    idle();

    wr(3, 32'hAABBCCDD, 4'b1111); step();
    wr(3, 32'h11223344, 4'b0101); step();
    rd_a(3); step();
    chk("lane_merge", a_dout0, 32'hAA22CC44);
    chk("lane_valid", {31'b0, a_valid0}, 1);
    idle(); step();
    chk("valid_pulse", {31'b0, a_valid0}, 0);
    wr(3, 32'h0, 4'b0000); step();
    idle(); rd_a(3); step();
    chk("be0_noop", a_dout0, 32'hAA22CC44);

    idle(); wr(5, 32'h12345678, 4'b1111); step();
    wr(5, 32'hFFFFFFFF, 4'b0011); rd_b(5); step();
    chk("coll_mode0", b_dout0, 32'h12345678);
    chk("coll_mode1", b_dout1, 32'h1234FFFF);
    idle(); rd_b(5); rd_a(5); step();
    chk("coll_after0", b_dout0, 32'h1234FFFF);
    chk("coll_after1", b_dout1, 32'h1234FFFF);
    chk("coll_a_eq_b", a_dout0, 32'h1234FFFF);

    idle(); wr(4, 32'hCAFEF00D, 4'b1111); step();
    idle(); rd_a(3); step();
    wr(20, 32'h0, 4'b1111); step();
    chk("oor_wr_err", {31'b0, a_err0}, 1);
    idle(); rd_a(20); rd_b(20); step();
    chk("oor_rd_err", {31'b0, a_err0}, 1);
    chk("oor_rd_valid", {31'b0, a_valid0}, 0);
    chk("oor_dout_hold", a_dout0, 32'hAA22CC44);
    chk("oor_b_err", {31'b0, b_err0}, 1);
    idle(); rd_a(4); step();
    chk("no_alias", a_dout0, 32'hCAFEF00D);

    for (int i = 0; i < DPTH; i++) begin
      wr(i, 32'h01010101 * (i + 1), 4'b1111); step();
    end
    idle(); clr_req = 1; wr(2, 32'hDEADBEEF, 4'b1111); step();
    clr_req = 0;
    wr(2, 32'h5A5A5A5A, 4'b1111); rd_b(2);
    count_busy("busy_after_clr");
    idle();
    for (int i = 0; i < DPTH; i++) begin
      rd_a(i); rd_b(DPTH - 1 - i); step();
      chk("cleared_a", a_dout0, 32'h0);
      chk("cleared_b", b_dout1, 32'h0);
    end

    idle(); wr(1, 32'h55, 4'b1111); step();
    idle(); rd_a(1); rd_b(1); step();
    idle(); clr_req = 1; step();
    clr_req = 0;
    for (int i = 0; i < 7; i++) step();
    #2 reset = 1;
    #1;
    chk("async_a_dout", a_dout0, 32'h0);
    chk("async_b_dout", b_dout1, 32'h0);
    chk("async_busy", {31'b0, busy0}, 1);
    step(); step();
    reset = 0;
    count_busy("busy_after_midreset");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
